// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a one-deep
// holding register with valid/ready handshake, framing-error and overrun pulses.
module uart_rx #(
    parameter int unsigned BAUD_DIV = 694,
    parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       ferr_o,
    output logic       ovf_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(HALF_DIV - 1);

    logic [1:0]  sync_reg;
    logic        rx_s;

    logic [2:0]  state_reg, state_next;
    logic [15:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic        done_reg, done_next;
    logic        ferr_reg, ferr_next;
    logic [7:0]  data_reg;
    logic        valid_reg;
    logic        ovf_reg;
    logic        tick;

    // Synchronizer chain; stages reset to the idle line level.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic stage_in;
            if (gi == 0) begin : g_first
                assign stage_in = rx_i;
            end else begin : g_rest
                assign stage_in = sync_reg[gi-1];
            end
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    sync_reg[gi] <= 1'b1;
                end else begin
                    sync_reg[gi] <= stage_in;
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    assign tick = ((state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP))
                  && (baud_cnt_reg == 16'd0);

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shreg_next    = shreg_reg;
        done_next     = 1'b0;
        ferr_next     = 1'b0;

        if ((state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP)) begin
            baud_cnt_next = tick ? BAUD_RELOAD : (baud_cnt_reg - 16'd1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next    = ST_START;
                    baud_cnt_next = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next   = ST_DATA;
                        bit_idx_next = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_next = {rx_s, shreg_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_BREAK;
                        ferr_next  = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= 16'd0;
            bit_idx_reg  <= 3'd0;
            shreg_reg    <= 8'd0;
            done_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shreg_reg    <= shreg_next;
            done_reg     <= done_next;
            ferr_reg     <= ferr_next;
        end
    end

    // Holding register: a completion may replace a byte being consumed in the same cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_reg  <= 8'd0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;
            if (done_reg) begin
                if (!valid_reg || ready_i) begin
                    data_reg  <= shreg_reg;
                    valid_reg <= 1'b1;
                end else begin
                    ovf_reg <= 1'b1;
                end
            end else if (valid_reg && ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data_o  = data_reg;
    assign valid_o = valid_reg;
    assign busy_o  = (state_reg != ST_IDLE);
    assign ferr_o  = ferr_reg;
    assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level timing model (latency formula, busy windows,
// one-deep holding register) compared every cycle, plus directed literal checks.
module tb_uart_rx;

    localparam int BAUD     = 16;
    localparam int HALF     = BAUD / 2;
    localparam int DONE_OFS = 3 + HALF + 9 * BAUD;   // start edge -> valid_o visible
    localparam int STOP_OFS = 2 + HALF + 9 * BAUD;   // start edge -> stop-bit sample
    localparam int INF      = 32'h3fff_ffff;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, busy, ferr, ovf;

    uart_rx #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
        .clk_i   (clk),
        .arst_n_i(arst_n),
        .rx_i    (rx),
        .data_o  (data),
        .valid_o (valid),
        .ready_i (ready),
        .busy_o  (busy),
        .ferr_o  (ferr),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {int at; bit is_ferr; logic [7:0] byte_v;} ev_t;
    typedef struct {int lo; int hi;} iv_t;

    ev_t  evq[$];
    iv_t  ivq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic       mvalid = 1'b0;
    logic [7:0] mdata = 8'd0;

    // Observed-output statistics for the directed checks.
    logic       prev_valid = 1'b0;
    int         rise_cyc = -1;
    logic [7:0] rise_data = 8'd0;
    int         n_valid_cyc = 0;
    int         n_ovf = 0;
    int         n_ferr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model and compare, once per clock, 1 ns after the rising edge.
    initial begin
        logic       exp_ferr, exp_ovf, exp_busy, comp;
        logic [7:0] cbyte;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!arst_n) begin
                evq.delete();
                ivq.delete();
                mvalid = 1'b0;
                mdata  = 8'd0;
                check("rst_data", {24'd0, data}, 32'd0);
                check("rst_valid", {31'd0, valid}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_ferr", {31'd0, ferr}, 32'd0);
                check("rst_ovf", {31'd0, ovf}, 32'd0);
            end else begin
                exp_ferr = 1'b0;
                exp_ovf  = 1'b0;
                comp     = 1'b0;
                cbyte    = 8'd0;
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].at == cyc) begin
                        if (evq[i].is_ferr) exp_ferr = 1'b1;
                        else begin
                            comp  = 1'b1;
                            cbyte = evq[i].byte_v;
                        end
                        evq.delete(i);
                    end
                end
                if (comp) begin
                    if (!mvalid || ready) begin
                        mvalid = 1'b1;
                        mdata  = cbyte;
                        $display("[%0d] byte %02h completed, loaded", cyc, cbyte);
                    end else begin
                        exp_ovf = 1'b1;
                        $display("[%0d] byte %02h completed, dropped (holding full)", cyc, cbyte);
                    end
                end else if (mvalid && ready) begin
                    mvalid = 1'b0;
                    $display("[%0d] byte %02h consumed", cyc, mdata);
                end
                if (exp_ferr) $display("[%0d] framing error expected", cyc);
                exp_busy = 1'b0;
                foreach (ivq[i]) if (cyc >= ivq[i].lo && cyc <= ivq[i].hi) exp_busy = 1'b1;

                check("valid", {31'd0, valid}, {31'd0, mvalid});
                if (mvalid) check("data", {24'd0, data}, {24'd0, mdata});
                check("busy", {31'd0, busy}, {31'd0, exp_busy});
                check("ferr", {31'd0, ferr}, {31'd0, exp_ferr});
                check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
            end
            if (valid && !prev_valid) begin
                rise_cyc  = cyc;
                rise_data = data;
            end
            if (valid) n_valid_cyc++;
            if (ovf)   n_ovf++;
            if (ferr)  n_ferr++;
            prev_valid = valid;
        end
    end

    // Called at a falling edge; returns the index of the first rising edge seeing the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int k);
        k = cyc + 1;
        if (stop) begin
            ivq.push_back('{lo: k + 2, hi: k + 1 + HALF + 9 * BAUD});
            evq.push_back('{at: k + DONE_OFS, is_ferr: 1'b0, byte_v: b});
        end else begin
            ivq.push_back('{lo: k + 2, hi: INF});
            evq.push_back('{at: k + STOP_OFS, is_ferr: 1'b1, byte_v: b});
        end
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop;
        repeat (BAUD) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k, ka, kb, h, comp2, v0, o0, f0;
        logic [7:0] b77;
        b77 = 8'h77;

        // Reset with a toggling line, then idle line.
        arst_n = 1'b0;
        rx     = 1'b1;
        ready  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx = i[0];
            @(negedge clk);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        v0 = n_valid_cyc;
        repeat (100) @(negedge clk);
        check("idle_no_valid", n_valid_cyc - v0, 0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single byte with consumer always ready.
        ready = 1'b1;
        v0 = n_valid_cyc; o0 = n_ovf; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, k);
        repeat (10) @(negedge clk);
        check("a5_latency", rise_cyc - k, 155);
        check("a5_data", {24'd0, rise_data}, 32'h0000_00A5);
        check("a5_pulse_cycles", n_valid_cyc - v0, 1);
        check("a5_no_err", (n_ovf - o0) + (n_ferr - f0), 0);

        // Back-to-back frames into a stalled consumer.
        ready = 1'b0;
        o0 = n_ovf;
        send_frame(8'h00, 1'b1, k);
        send_frame(8'hFF, 1'b1, k);
        send_frame(8'h3C, 1'b1, k);
        repeat (5) @(negedge clk);
        check("stall_valid", {31'd0, valid}, 32'd1);
        check("stall_data", {24'd0, data}, 32'h0000_0000);
        check("stall_ovf_count", n_ovf - o0, 2);
        ready = 1'b1;
        @(negedge clk);
        check("stall_release", {31'd0, valid}, 32'd0);
        ready = 1'b0;

        // Accept of byte 1 coincides with completion of byte 2.
        repeat (20) @(negedge clk);
        o0 = n_ovf;
        comp2 = cyc + 1 + 10 * BAUD + DONE_OFS;
        fork
            begin
                send_frame(8'h18, 1'b1, ka);
                send_frame(8'h81, 1'b1, kb);
            end
            begin
                while (cyc < comp2 - 1) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        check("simul_valid", {31'd0, valid}, 32'd1);
        check("simul_data", {24'd0, data}, 32'h0000_0081);
        check("simul_no_ovf", n_ovf - o0, 0);
        check("simul_comp_cycle", kb - ka, 10 * BAUD);

        // Framing error followed by a held-low line.
        ready = 1'b1;
        @(negedge clk);
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovf;
        send_frame(8'h55, 1'b0, k);
        repeat (40) @(negedge clk);
        check("break_busy", {31'd0, busy}, 32'd1);
        h = cyc + 1;
        rx = 1'b1;
        ivq[ivq.size() - 1].hi = h + 1;
        repeat (10) @(negedge clk);
        check("break_exit_busy", {31'd0, busy}, 32'd0);
        check("ferr_pulse_cycles", n_ferr - f0, 1);
        check("ferr_no_valid", n_valid_cyc - v0, 0);
        check("ferr_no_ovf", n_ovf - o0, 0);
        repeat (20) @(negedge clk);
        send_frame(8'h12, 1'b1, k);
        repeat (5) @(negedge clk);
        check("after_ferr_data", {24'd0, rise_data}, 32'h0000_0012);

        // Short glitch on an idle line.
        v0 = n_valid_cyc; f0 = n_ferr; o0 = n_ovf;
        k = cyc + 1;
        ivq.push_back('{lo: k + 2, hi: k + 1 + HALF});
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_valid", n_valid_cyc - v0, 0);
        check("glitch_no_pulse", (n_ferr - f0) + (n_ovf - o0), 0);

        // Reset in the middle of data bit 3 of 0x77.
        k = cyc + 1;
        ivq.push_back('{lo: k + 2, hi: INF});
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b77[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = b77[3];
        repeat (BAUD / 2) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        arst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        arst_n = 1'b1;
        repeat (50) @(negedge clk);
        send_frame(8'h42, 1'b1, k);
        repeat (5) @(negedge clk);
        check("post_reset_data", {24'd0, rise_data}, 32'h0000_0042);
        check("post_reset_latency", rise_cyc - k, 155);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver: the receive end of the 8N1 link whose transmit end drives tx_o on the sigma SoC.
- Used in host-side test harnesses and loopback bring-up on the NEXYS4-DDR build. It also serves as the receive front end of the UART debug bridge.
- Converts the asynchronous serial line into bytes with a valid/ready handshake. Reports framing and overrun errors.

Parameters:
- BAUD_DIV, 694, clock cycles per bit (80 MHz / 115200, truncated); legal range 8..65535.
- HALF_DIV, BAUD_DIV/2, cycles from start-edge detection to start-bit centre; integer division.

Ports:
- clk_i  in  1  system clock (CLK_80MHZ domain)
- arst_n_i  in  1  asynchronous active-low reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- data_o  out  8  received byte, valid while valid_o=1
- valid_o  out  1  byte available
- ready_i  in  1  consumer accepts byte when valid_o&ready_i
- busy_o  out  1  frame reception in progress (state != IDLE)
- ferr_o  out  1  one-cycle pulse: stop bit sampled low
- ovf_o  out  1  one-cycle pulse: completed byte dropped because holding register full

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_n_i is asynchronous and active-low. All flops clear on arst_n_i=0.
- Reset values: synchronizer flops=1, state=IDLE, bit counter=0, baud counter=0, shift register=0, data_o=0, valid_o=0, busy_o=0, ferr_o=0, ovf_o=0.
- Synchronizer: rx_i passes through two flops (rx_s). All decisions use rx_s, so input-to-rx_s latency is 2 cycles.
- Baud counter: 16-bit down-counter.
  - A "tick" occurs when the counter is 0 in an active state.
  - On each tick the counter reloads BAUD_DIV-1.
- IDLE:
  - rx_s=0 -> go to START and load the counter with HALF_DIV-1.
  - Otherwise stay in IDLE.
- START:
  - On tick, sample rx_s.
  - rx_s=1 is a glitch: return to IDLE, with no pulse and no data.
  - rx_s=0: go to DATA with bit index 0.
- DATA:
  - On each tick, shift rx_s into the shift register LSB-first (shreg <= {rx_s, shreg[7:1]}).
  - After the 8th sample (index 7), go to STOP.
- STOP: on tick, sample rx_s.
  - rx_s=1: the frame is good; return to IDLE and perform completion (below).
  - rx_s=0: pulse ferr_o for exactly 1 cycle, discard the byte, go to BREAK.
- BREAK:
  - Wait until rx_s=1, then go to IDLE. This prevents re-triggering on a held-low line.
  - busy_o stays 1 in BREAK.
- Completion, in the cycle after the stop tick:
  - If valid_o=0, or valid_o=1 & ready_i=1 in that same cycle: data_o<=shreg and valid_o<=1. The old byte is consumed and the new one is loaded with no bubble.
  - If valid_o=1 & ready_i=0: data_o and valid_o are unchanged, the new byte is dropped, and ovf_o pulses for 1 cycle.
- Handshake:
  - valid_o, once set, stays 1 and data_o stays stable until a cycle with ready_i=1.
  - valid_o clears on that cycle unless a completion loads a new byte in the same cycle.
  - ready_i has no effect while valid_o=0.
- Latency: from the rx_i falling edge (start bit) to valid_o=1 is 2 + HALF_DIV + 9*BAUD_DIV + 1 cycles (±1 for edge alignment). Receiving continues independently of the handshake.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit centre, so a start bit arriving half a bit later is detected.
  - No inter-frame gap is required.
- Reset mid-frame: the partial frame is lost. After release, the receiver starts in IDLE and waits for rx_s=0.
  - Releasing reset while the line is low mid-byte may yield a spurious frame; this is accepted behaviour.
- ferr_o and ovf_o are never asserted in the same cycle.

Test Plan:
- Reset: hold arst_n_i=0 with rx_i toggling -> all outputs 0, busy_o=0. After release with rx_i=1 for 100 cycles -> no valid_o.
- Single byte: BAUD_DIV=16; send 0xA5 (8N1, LSB first) with ready_i=1 -> valid_o pulses for 1 cycle with data_o=0xA5 about 2+8+144+1=155 cycles after the start edge. ferr_o=0 and ovf_o=0.
- Back-to-back and stall: send 0x00, 0xFF, 0x3C with no gaps, ready_i=0.
  - valid_o rises with data_o=0x00 and holds.
  - ovf_o pulses on the 0xFF and 0x3C completions; data_o stays 0x00.
  - Raise ready_i -> valid_o clears the next cycle.
- Simultaneous accept and complete: assert ready_i exactly in the completion cycle of the second byte 0x81 -> valid_o stays 1, data_o=0x81, no ovf_o.
- Framing error: send 0x55 with the stop bit driven 0, then hold the line low for 40 cycles -> ferr_o is a single-cycle pulse, no valid_o, busy_o=1 until the line returns high. The next 0x12 is received correctly.
- Glitch and mid-frame reset:
  - A 4-cycle low pulse on rx_i -> returns to IDLE, no outputs.
  - Assert arst_n_i during data bit 3 of 0x77 -> all outputs reset; the following 0x42 frame is received as 0x42.
